// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for the sequential binary32 multiplier.
// The producer side uses master; the multiplier core uses slave.
interface fp_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf
  );

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 binary32 multiplier: 24-step shift-add mantissa product,
// one normalise/round cycle, flush-to-zero for subnormal inputs.
module fp_mul_seq #(
  parameter int          MUL_STEPS = 24,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic          clk,
  input  logic          rst,
  fp_mul_seq_if.slave   bus,
  output logic [22:0]   frc_X,
  output logic [22:0]   frc_Y,
  output logic [47:0]   frc_Z_full
);

  typedef enum logic [1:0] {IDLE, MUL, NORM_RND, DONE} state_t;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rnd_t;

  function automatic rnd_t decode_mode(input logic [2:0] m);
    case (m)
      3'd1:    return RTZ;
      3'd2:    return RDN;
      3'd3:    return RUP;
      3'd4:    return RMM;
      default: return RNE;
    endcase
  endfunction

  state_t       state, state_d;
  logic [4:0]   cnt;
  logic         sign_q;
  logic [7:0]   ex_q, ey_q;
  rnd_t         mode_q;
  logic         spec_q;
  logic [31:0]  spec_z_q;
  logic [47:0]  mcand_q;
  logic [23:0]  mplier_q;
  logic         accept;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid && (state == IDLE);

  // Operand classification, evaluated on the live inputs at acceptance.
  logic [7:0]  x_e, y_e;
  logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  logic        sign_in, spec_hit;
  logic [31:0] spec_z;

  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment or a leading default) so no latch is inferred.
  always_comb begin
    x_e      = bus.fp_X[30:23];
    y_e      = bus.fp_Y[30:23];
    x_nan    = (&x_e) & (|bus.fp_X[22:0]);
    y_nan    = (&y_e) & (|bus.fp_Y[22:0]);
    x_inf    = (&x_e) & ~(|bus.fp_X[22:0]);
    y_inf    = (&y_e) & ~(|bus.fp_Y[22:0]);
    x_zero   = ~(|x_e);
    y_zero   = ~(|y_e);
    sign_in  = bus.fp_X[31] ^ bus.fp_Y[31];
    spec_hit = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      spec_z = CANON_NAN;
    else if (x_inf || y_inf)
      spec_z = {sign_in, 8'hFF, 23'd0};
    else
      spec_z = {sign_in, 31'd0};
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (accept) state_d = spec_hit ? NORM_RND : MUL;
      MUL:      if (cnt == 5'(MUL_STEPS - 1)) state_d = NORM_RND;
      NORM_RND: state_d = DONE;
      DONE:     if (bus.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Normalise and round the finished 48-bit product.
  logic signed [9:0] e_base, e_norm, e_fin;
  logic [22:0]       mant, mant_f;
  logic [23:0]       mant_r;
  logic              g, s, inc;
  logic [31:0]       res_z;
  logic              res_o, res_u;

  always_comb begin
    e_base = $signed({2'b00, ex_q}) + $signed({2'b00, ey_q}) - 10'sd127;
    if (frc_Z_full[47]) begin
      mant   = frc_Z_full[46:24];
      g      = frc_Z_full[23];
      s      = |frc_Z_full[22:0];
      e_norm = e_base + 10'sd1;
    end else begin
      mant   = frc_Z_full[45:23];
      g      = frc_Z_full[22];
      s      = |frc_Z_full[21:0];
      e_norm = e_base;
    end

    case (mode_q)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign_q & (g | s);
      RUP:     inc = ~sign_q & (g | s);
      RMM:     inc = g;
      default: inc = g & (s | mant[0]);
    endcase

    mant_r = {1'b0, mant} + {23'd0, inc};
    if (mant_r[23]) begin
      mant_f = 23'd0;
      e_fin  = e_norm + 10'sd1;
    end else begin
      mant_f = mant_r[22:0];
      e_fin  = e_norm;
    end

    res_o = 1'b0;
    res_u = 1'b0;
    res_z = {sign_q, e_fin[7:0], mant_f};
    if (e_fin >= 10'sd255) begin
      res_o = 1'b1;
      case (mode_q)
        RTZ:     res_z = {sign_q, 31'h7F7FFFFF};
        RDN:     res_z = sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
        RUP:     res_z = sign_q ? 32'hFF7FFFFF : 32'h7F800000;
        default: res_z = {sign_q, 8'hFF, 23'd0};
      endcase
    end else if (e_fin <= 10'sd0) begin
      res_u = 1'b1;
      res_z = {sign_q, 31'd0};
    end
  end

  // NOTE: state is written only with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      sign_q     <= 1'b0;
      ex_q       <= 8'd0;
      ey_q       <= 8'd0;
      mode_q     <= RNE;
      spec_q     <= 1'b0;
      spec_z_q   <= 32'd0;
      mcand_q    <= 48'd0;
      mplier_q   <= 24'd0;
      frc_X      <= 23'd0;
      frc_Y      <= 23'd0;
      frc_Z_full <= 48'd0;
      bus.fp_Z   <= 32'd0;
      bus.ovrf   <= 1'b0;
      bus.udrf   <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (accept) begin
          sign_q     <= sign_in;
          ex_q       <= x_e;
          ey_q       <= y_e;
          mode_q     <= decode_mode(bus.r_mode);
          spec_q     <= spec_hit;
          spec_z_q   <= spec_z;
          frc_X      <= bus.fp_X[22:0];
          frc_Y      <= bus.fp_Y[22:0];
          mcand_q    <= {24'd0, 1'b1, bus.fp_X[22:0]};
          mplier_q   <= {1'b1, bus.fp_Y[22:0]};
          frc_Z_full <= 48'd0;
          cnt        <= 5'd0;
        end
        MUL: begin
          if (mplier_q[0]) frc_Z_full <= frc_Z_full + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt      <= cnt + 5'd1;
        end
        NORM_RND: begin
          bus.fp_Z <= spec_q ? spec_z_q : res_z;
          bus.ovrf <= ~spec_q & res_o;
          bus.udrf <= ~spec_q & res_u;
        end
        default: ;
      endcase
    end
  end

endmodule
